// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the two requester ports and the shared memory port of mem_arbiter.
//   slave  : arbiter view. Takes requests and memory read data. Drives acks,
//            per-port read data, memory address/data/strobes and busy.
//   master : environment view. Requesters on port 0 (instruction fetch) and
//            port 1 (load/store), plus the memory model that drives mem_out.
// Ports carried:
//   p0_/p1_ req, we, addr[23:0], wdata[31:0]  requester -> arbiter
//   p0_/p1_ ack, rdata[31:0]                  arbiter -> requester
//   mem_dira[23:0], mem_write_data[31:0],
//   mem_memwrite, mem_memread                 arbiter -> memory
//   mem_out[31:0]                             memory -> arbiter
//   busy                                      arbiter status
interface mem_arbiter_if;

  logic        p0_req;
  logic        p0_we;
  logic [23:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_ack;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [23:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic [31:0] p1_rdata;

  logic [23:0] mem_dira;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_out;

  logic        busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_out,
    output p0_ack, p0_rdata,
    output p1_ack, p1_rdata,
    output mem_dira, mem_write_data, mem_memwrite, mem_memread,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_out,
    input  p0_ack, p0_rdata,
    input  p1_ack, p1_rdata,
    input  mem_dira, mem_write_data, mem_memwrite, mem_memread,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port round-robin arbiter and access sequencer for the shared mem_64M
// memory (24-bit word address, 32-bit data). One transaction at a time:
// IDLE -> ACCESS -> (WAIT for reads) -> DONE -> IDLE. Memory controls are
// held stable for the whole access, each transaction returns a one-cycle ack
// on its port, and read data is registered per port.
// Parameters:
//   READ_LAT : cycles from mem_memread first asserted to mem_out valid (1..4)
//   P1_FIRST : 1 = port 1 wins the first tie after reset, 0 = port 0 does
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (requester ports, memory port, busy)
module mem_arbiter #(
  parameter int unsigned READ_LAT = 1,
  parameter bit          P1_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT);

  state_t      state;
  state_t      state_nxt;

  // Latched transaction
  logic        grant;       // 0 = port 0, 1 = port 1
  logic        last_grant;
  logic        we_q;
  logic [23:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  lat_cnt;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  // Arbitration
  logic        sel;

  // FSM controls
  logic        load;
  logic        lat_load;
  logic        lat_dec;
  logic        capture;
  logic        memwrite;
  logic        memread;
  logic        ack0;
  logic        ack1;
  logic        busy;

  // A lone requester wins outright; on a tie the port that did not win last
  // time gets the grant.
  assign sel = (bus.p0_req & bus.p1_req) ? ~last_grant : bus.p1_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes, acks and busy are decoded from state and the latched we only,
  // so the asynchronous state reset takes them low immediately.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    lat_load  = 1'b0;
    lat_dec   = 1'b0;
    capture   = 1'b0;
    memwrite  = 1'b0;
    memread   = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.p0_req | bus.p1_req) begin
          load      = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          memwrite  = 1'b1;
          state_nxt = DONE;
        end else begin
          memread   = 1'b1;
          lat_load  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        memread = 1'b1;
        lat_dec = 1'b1;
        if (lat_cnt == 3'd1) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        ack0      = ~grant;
        ack1      = grant;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= 1'b0;
      last_grant <= ~P1_FIRST;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_cnt    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      if (load) begin
        grant      <= sel;
        last_grant <= sel;
        we_q       <= sel ? bus.p1_we    : bus.p0_we;
        addr_q     <= sel ? bus.p1_addr  : bus.p0_addr;
        wdata_q    <= sel ? bus.p1_wdata : bus.p0_wdata;
      end
      if (lat_load) begin
        lat_cnt <= LAT_INIT;
      end else if (lat_dec) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      if (capture) begin
        if (grant) begin
          rdata1_q <= bus.mem_out;
        end else begin
          rdata0_q <= bus.mem_out;
        end
      end
    end
  end

  assign bus.mem_dira       = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_memwrite   = memwrite;
  assign bus.mem_memread    = memread;
  assign bus.p0_ack         = ack0;
  assign bus.p1_ack         = ack1;
  assign bus.p0_rdata       = rdata0_q;
  assign bus.p1_rdata       = rdata1_q;
  assign bus.busy           = busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Instance a: READ_LAT=1, P1_FIRST=1.
// Instance b: READ_LAT=3, P1_FIRST=0. Each instance has a small memory model
// whose mem_out is valid only in the cycle READ_LAT cycles after mem_memread
// rises. Expected acks are queued when requests are driven and compared as
// the acks appear.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  mem_arbiter_if ia ();
  mem_arbiter_if ib ();

  mem_arbiter #(.READ_LAT(1), .P1_FIRST(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  mem_arbiter #(.READ_LAT(3), .P1_FIRST(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  int          rdc_a = 0;
  int          rdc_b = 0;

  always @(posedge clk) begin
    if (ia.mem_memwrite) mem_a[ia.mem_dira[7:0]] <= ia.mem_write_data;
    if (ib.mem_memwrite) mem_b[ib.mem_dira[7:0]] <= ib.mem_write_data;
    rdc_a <= (rst_n && ia.mem_memread) ? rdc_a + 1 : 0;
    rdc_b <= (rst_n && ib.mem_memread) ? rdc_b + 1 : 0;
  end

  assign ia.mem_out = (ia.mem_memread && rdc_a == 1) ? mem_a[ia.mem_dira[7:0]] : 32'hBAD0BAD0;
  assign ib.mem_out = (ib.mem_memread && rdc_b == 3) ? mem_b[ib.mem_dira[7:0]] : 32'hBAD0BAD0;

  // Scoreboard
  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int checks = 0;
  int errors = 0;

  // Monitor-owned counters
  int          wr_cyc_a = 0;
  logic [23:0] wr_addr_a = '0;
  logic [31:0] wr_data_a = '0;
  int          rd_cyc_a = 0;
  int          rd_cyc_b = 0;
  int          moved_b = 0;
  logic        rd_prev_b = 1'b0;
  logic [23:0] dira_prev_b = '0;
  int          ack_cnt_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ia.mem_memwrite) begin
        wr_cyc_a++;
        wr_addr_a = ia.mem_dira;
        wr_data_a = ia.mem_write_data;
      end
      if (ia.mem_memread) rd_cyc_a++;
      if (ib.mem_memread) begin
        rd_cyc_b++;
        if (rd_prev_b && ib.mem_dira != dira_prev_b) moved_b++;
      end
      rd_prev_b   = ib.mem_memread;
      dira_prev_b = ib.mem_dira;
      if (ib.p0_ack || ib.p1_ack) ack_cnt_b++;
      if (rst_n && (ia.p0_ack || ia.p1_ack)) begin
        if (sb_a.size() == 0) begin
          check("a_spurious_ack", 32'({ia.p1_ack, ia.p0_ack}), 32'd0);
        end else begin
          e = sb_a.pop_front();
          check("a_ack_port", 32'({ia.p1_ack, ia.p0_ack}), e.port ? 32'd2 : 32'd1);
          if (!e.we) check("a_rdata", e.port ? ia.p1_rdata : ia.p0_rdata, e.rdata);
        end
      end
      if (rst_n && (ib.p0_ack || ib.p1_ack)) begin
        if (sb_b.size() == 0) begin
          check("b_spurious_ack", 32'({ib.p1_ack, ib.p0_ack}), 32'd0);
        end else begin
          e = sb_b.pop_front();
          check("b_ack_port", 32'({ib.p1_ack, ib.p0_ack}), e.port ? 32'd2 : 32'd1);
          if (!e.we) check("b_rdata", e.port ? ib.p1_rdata : ib.p0_rdata, e.rdata);
        end
      end
    end
  endtask

  task automatic drive(input bit on_b, input bit p, input bit req, input bit we,
                       input logic [23:0] addr, input logic [31:0] wdata);
    if (!on_b && !p) begin
      ia.p0_req = req; ia.p0_we = we; ia.p0_addr = addr; ia.p0_wdata = wdata;
    end else if (!on_b && p) begin
      ia.p1_req = req; ia.p1_we = we; ia.p1_addr = addr; ia.p1_wdata = wdata;
    end else if (on_b && !p) begin
      ib.p0_req = req; ib.p0_we = we; ib.p0_addr = addr; ib.p0_wdata = wdata;
    end else begin
      ib.p1_req = req; ib.p1_we = we; ib.p1_addr = addr; ib.p1_wdata = wdata;
    end
  endtask

  task automatic drop(input bit on_b, input bit p);
    if (!on_b && !p) ia.p0_req = 1'b0;
    else if (!on_b && p) ia.p1_req = 1'b0;
    else if (on_b && !p) ib.p0_req = 1'b0;
    else ib.p1_req = 1'b0;
  endtask

  // Counts rising edges until an ack is seen at a falling edge; port=-1 on timeout.
  task automatic wait_ack(input bit on_b, input int budget, output int lat, output int port);
    lat  = 0;
    port = -1;
    while (port < 0 && lat < budget) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (on_b) begin
        if (ib.p0_ack) port = 0;
        else if (ib.p1_ack) port = 1;
      end else begin
        if (ia.p0_ack) port = 0;
        else if (ia.p1_ack) port = 1;
      end
    end
  endtask

  // One complete transaction from an idle arbiter, followed by the idle cycle.
  task automatic xact(input bit on_b, input bit p, input bit we, input logic [23:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input int exp_lat, input string tag);
    int lat;
    int port;
    drive(on_b, p, 1'b1, we, addr, wdata);
    if (on_b) sb_b.push_back('{port: p, we: we, rdata: exp_rdata});
    else      sb_a.push_back('{port: p, we: we, rdata: exp_rdata});
    wait_ack(on_b, exp_lat + 6, lat, port);
    drop(on_b, p);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_port"}, port, 32'(p));
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input bit on_b, input string tag);
    if (on_b) begin
      check({tag, "_ctrl"}, 32'({ib.p0_ack, ib.p1_ack, ib.mem_memwrite, ib.mem_memread, ib.busy}), 32'd0);
      check({tag, "_dira"}, 32'(ib.mem_dira), 32'd0);
      check({tag, "_wdata"}, ib.mem_write_data, 32'd0);
      check({tag, "_rdata0"}, ib.p0_rdata, 32'd0);
      check({tag, "_rdata1"}, ib.p1_rdata, 32'd0);
    end else begin
      check({tag, "_ctrl"}, 32'({ia.p0_ack, ia.p1_ack, ia.mem_memwrite, ia.mem_memread, ia.busy}), 32'd0);
      check({tag, "_dira"}, 32'(ia.mem_dira), 32'd0);
      check({tag, "_wdata"}, ia.mem_write_data, 32'd0);
      check({tag, "_rdata0"}, ia.p0_rdata, 32'd0);
      check({tag, "_rdata1"}, ia.p1_rdata, 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int port;
    int snap;
    int snap2;
    int n0;
    int n1;

    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    #1 rst_n = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_reset_outputs(1'b0, "a_rst");
    check_reset_outputs(1'b1, "b_rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Port 0 write: single write strobe cycle, ack two edges after sampling
    snap = wr_cyc_a;
    xact(1'b0, 1'b0, 1'b1, 24'h000010, 32'hDEADBEEF, 32'h0, 2, "a_wr0");
    check("a_wr0_strobe_cycles", wr_cyc_a - snap, 1);
    check("a_wr0_addr", 32'(wr_addr_a), 32'h10);
    check("a_wr0_data", wr_data_a, 32'hDEADBEEF);
    check("a_idle_busy", 32'(ia.busy), 32'd0);

    // Port 1 read back through the one-cycle-latency memory
    snap = rd_cyc_a;
    xact(1'b0, 1'b1, 1'b0, 24'h000010, 32'h0, 32'hDEADBEEF, 3, "a_rd1");
    check("a_rd1_strobe_cycles", rd_cyc_a - snap, 2);
    check("a_rd1_p0_rdata_kept", ia.p0_rdata, 32'd0);

    // Port 0 read, then a port 1 write that must not disturb p1_rdata
    xact(1'b0, 1'b0, 1'b0, 24'h000010, 32'h0, 32'hDEADBEEF, 3, "a_rd0");
    xact(1'b0, 1'b1, 1'b1, 24'h000020, 32'h12345678, 32'h0, 2, "a_wr1");
    check("a_wr1_p1_rdata_kept", ia.p1_rdata, 32'hDEADBEEF);
    check("a_wr1_mem", mem_a[8'h20], 32'h12345678);

    // Port 1 drops req one cycle after grant: access still completes once
    snap = rd_cyc_a;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h000020, 32'h0);
    sb_a.push_back('{port: 1'b1, we: 1'b0, rdata: 32'h12345678});
    @(posedge clk);
    @(negedge clk);
    drop(1'b0, 1'b1);
    wait_ack(1'b0, 8, lat, port);
    check("a_drop_lat", lat, 2);
    check("a_drop_port", port, 1);
    repeat (4) @(negedge clk);
    check("a_drop_strobe_cycles", rd_cyc_a - snap, 2);
    check("a_drop_busy", 32'(ia.busy), 32'd0);

    // Tie after reset on a: port 1 first, then strict alternation
    do_reset();
    check_reset_outputs(1'b0, "a_rst2");
    for (int k = 0; k < 6; k++) begin
      sb_a.push_back('{port: (k % 2 == 0), we: 1'b1, rdata: 32'h0});
    end
    n0 = 0;
    n1 = 0;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 24'h000040, 32'h11110000);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 24'h000050, 32'h22220000);
    for (int k = 0; k < 6; k++) begin
      wait_ack(1'b0, 10, lat, port);
      check("a_tie_order", port, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("a_tie_lat", lat, (k == 0) ? 32'd2 : 32'd3);
      if (port == 1) begin
        n1++;
        if (n1 < 3) drive(1'b0, 1'b1, 1'b1, 1'b1, 24'h000040 + 24'(n1), 32'h11110000 + 32'(n1));
        else drop(1'b0, 1'b1);
      end else if (port == 0) begin
        n0++;
        if (n0 < 3) drive(1'b0, 1'b0, 1'b1, 1'b1, 24'h000050 + 24'(n0), 32'h22220000 + 32'(n0));
        else drop(1'b0, 1'b0);
      end else begin
        drop(1'b0, 1'b0);
        drop(1'b0, 1'b1);
        break;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("a_tie_mem_p1", mem_a[8'h40 + 8'(i)], 32'h11110000 + 32'(i));
      check("a_tie_mem_p0", mem_a[8'h50 + 8'(i)], 32'h22220000 + 32'(i));
    end

    // Instance b (P1_FIRST=0): port 0 wins the first tie
    sb_b.push_back('{port: 1'b0, we: 1'b1, rdata: 32'h0});
    sb_b.push_back('{port: 1'b1, we: 1'b1, rdata: 32'h0});
    drive(1'b1, 1'b0, 1'b1, 1'b1, 24'h000060, 32'hAAAA0060);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 24'h000061, 32'hBBBB0061);
    wait_ack(1'b1, 8, lat, port);
    drop(1'b1, 1'b0);
    check("b_tie_first", port, 0);
    check("b_tie_first_lat", lat, 2);
    wait_ack(1'b1, 8, lat, port);
    drop(1'b1, 1'b1);
    check("b_tie_second", port, 1);
    check("b_tie_second_lat", lat, 3);
    @(negedge clk);

    // READ_LAT=3 read: address held for 4 cycles, ack at E+5
    xact(1'b1, 1'b1, 1'b1, 24'h0000DE, 32'hCAFEF00D, 32'h0, 2, "b_wr1");
    snap  = rd_cyc_b;
    snap2 = moved_b;
    xact(1'b1, 1'b0, 1'b0, 24'h0000DE, 32'h0, 32'hCAFEF00D, 5, "b_rd0");
    check("b_rd0_strobe_cycles", rd_cyc_b - snap, 4);
    check("b_rd0_dira_moves", moved_b - snap2, 0);
    check("b_rd0_p1_rdata_kept", ib.p1_rdata, 32'd0);

    // Reset asserted while b is in WAIT
    drive(1'b1, 1'b0, 1'b1, 1'b0, 24'h000060, 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("b_pre_abort_wait", 32'({ib.busy, ib.mem_memread}), 32'd3);
    rst_n = 1'b0;
    #1;
    check("b_abort_ctrl", 32'({ib.p0_ack, ib.p1_ack, ib.mem_memread, ib.mem_memwrite, ib.busy}), 32'd0);
    drop(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs(1'b1, "b_post_abort");
    check_reset_outputs(1'b0, "a_post_abort");
    snap = ack_cnt_b;
    repeat (6) @(negedge clk);
    check("b_abort_no_ack", ack_cnt_b - snap, 0);
    check("b_abort_idle", 32'(ib.busy), 32'd0);

    check("a_sb_drained", sb_a.size(), 0);
    check("b_sb_drained", sb_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
